// File: rtl/fcmp_pkg.sv
// Shared types and helpers for the shared single-precision compare unit.
package fcmp_pkg;

    typedef enum logic [1:0] {
        OP_FEQ = 2'b00,
        OP_FLT = 2'b01,
        OP_FLE = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_RESP = 2'd2
    } state_e;

    // Numeric encoding matches the ordering NEG < ZERO < POS.
    typedef enum logic [1:0] {
        CL_NEG  = 2'd0,
        CL_ZERO = 2'd1,
        CL_POS  = 2'd2
    } cls_e;

    localparam int EXP_MSB = 30;
    localparam int EXP_LSB = 23;

    // Latched request: operation plus both operands.
    typedef struct packed {
        op_e         op;
        logic [31:0] x1;
        logic [31:0] x2;
    } cmp_req_t;

    // Denormals flush to zero: any zero exponent is ZERO regardless of sign/mantissa.
    function automatic cls_e classify(input logic [31:0] x);
        if (x[EXP_MSB:EXP_LSB] == '0) return CL_ZERO;
        else if (!x[31])              return CL_POS;
        else                          return CL_NEG;
    endfunction

endpackage

// File: rtl/fcmp_core.sv
// Combinational feq/flt/fle evaluator using class-based ordering (no NaN handling).
module fcmp_core
    import fcmp_pkg::*;
(
    input  op_e         op,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic        y,
    output logic        err
);

    cls_e c1, c2;
    logic lt, eq;

    // Classify operands, order by class first, then by magnitude bits within a class.
    always_comb begin
        c1 = classify(x1);
        c2 = classify(x2);
        lt = 1'b0;
        eq = 1'b0;
        if (c1 != c2) begin
            lt = (c1 < c2);
        end else begin
            case (c1)
                CL_POS:  begin lt = (x1[30:0] < x2[30:0]); eq = (x1[30:0] == x2[30:0]); end
                CL_NEG:  begin lt = (x2[30:0] < x1[30:0]); eq = (x1[30:0] == x2[30:0]); end
                default: begin lt = 1'b0;                  eq = 1'b1;                   end
            endcase
        end
    end

    // Select the requested predicate; the reserved code reports an error and false.
    always_comb begin
        y   = 1'b0;
        err = 1'b0;
        case (op)
            OP_FEQ:  y = eq;
            OP_FLT:  y = lt;
            OP_FLE:  y = lt | eq;
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/fcmp_arbiter.sv
// Round-robin share of one registered compare unit between two requesters.
module fcmp_arbiter
    import fcmp_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [31:0]      req0_x1,
    input  logic [31:0]      req0_x2,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [31:0]      req1_x1,
    input  logic [31:0]      req1_x2,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic             rsp_y,
    output logic             rsp_err,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    state_e   state, state_nxt;
    cmp_req_t req_q;
    logic     own;         // owner of the in-flight op: 0 or 1
    logic     last_grant;
    logic     gnt;         // requester selected this cycle
    logic     rsp_hs;
    logic     accept_en;
    logic     accept;
    logic     core_y, core_err;

    // Alternate on contention; a lone requester wins outright.
    assign gnt        = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    assign rsp_hs     = (state == S_RESP) && (own ? rsp1_ready : rsp0_ready);
    // A new op can enter from IDLE, or in the same cycle the current response retires.
    assign accept_en  = (state == S_IDLE) || rsp_hs;
    assign req0_ready = accept_en && !gnt;
    assign req1_ready = accept_en &&  gnt;
    assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign rsp0_valid = (state == S_RESP) && !own;
    assign rsp1_valid = (state == S_RESP) &&  own;

    fcmp_core u_core (
        .op  (req_q.op),
        .x1  (req_q.x1),
        .x2  (req_q.x2),
        .y   (core_y),
        .err (core_err)
    );

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_CMP;
            S_CMP:   state_nxt = S_RESP;
            S_RESP:  if (rsp_hs) state_nxt = accept ? S_CMP : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Capture the granted request and remember who was served.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req_q      <= '0;
            own        <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            req_q      <= gnt ? cmp_req_t'{op_e'(req1_op), req1_x1, req1_x2}
                              : cmp_req_t'{op_e'(req0_op), req0_x1, req0_x2};
            own        <= gnt;
            last_grant <= gnt;
        end
    end

    // Register the compare result; held stable through RESP backpressure.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_y   <= 1'b0;
            rsp_err <= 1'b0;
        end else if (state == S_CMP) begin
            rsp_y   <= core_y;
            rsp_err <= core_err;
        end
    end

    // Saturating per-requester completion counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (rsp_hs) begin
            if (!own && cnt0 != '1) cnt0 <= cnt0 + 1'b1;
            if ( own && cnt1 != '1) cnt1 <= cnt1 + 1'b1;
        end
    end

endmodule

// File: tb/tb_fcmp_arbiter.sv
// Directed bench for fcmp_arbiter: compare cases, arbitration, backpressure, reset.
module tb_fcmp_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0]  req0_op, req1_op;
    logic [31:0] req0_x1, req0_x2, req1_x1, req1_x2;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic        rsp_y, rsp_err;
    logic [15:0] cnt0, cnt1;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    fcmp_arbiter #(.CNT_W(16)) dut (
        .clk(clk), .rstn(rstn),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_x1(req0_x1), .req0_x2(req0_x2),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_x1(req1_x1), .req1_x2(req1_x2),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_y(rsp_y), .rsp_err(rsp_err), .cnt0(cnt0), .cnt1(cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic v, input logic [1:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        if (r == 0) begin req0_valid = v; req0_op = op; req0_x1 = a; req0_x2 = b; end
        else        begin req1_valid = v; req1_op = op; req1_x1 = a; req1_x2 = b; end
    endtask

    // One isolated op from IDLE with fixed accept -> response latency of two cycles.
    task automatic do_op(input string tag, input int r, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic ey, input logic eerr);
        set_req(r, 1'b1, op, a, b);
        #1;
        chk({tag, "_rdy"}, (r == 0) ? req0_ready : req1_ready, 1);
        tick();
        set_req(r, 1'b0, 2'b00, 32'h0, 32'h0);
        #1;
        chk({tag, "_cmp_vld"}, {rsp0_valid, rsp1_valid}, 0);
        tick();
        chk({tag, "_vld"}, (r == 0) ? {rsp0_valid, rsp1_valid} : {rsp1_valid, rsp0_valid}, 2'b10);
        chk({tag, "_y"}, rsp_y, ey);
        chk({tag, "_err"}, rsp_err, eerr);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0;
        req0_valid = 0; req0_op = 0; req0_x1 = 0; req0_x2 = 0;
        req1_valid = 0; req1_op = 0; req1_x1 = 0; req1_x2 = 0;
        rsp0_ready = 1; rsp1_ready = 1;
        #12;
        chk("rst_vld", {rsp0_valid, rsp1_valid}, 0);
        chk("rst_y", {rsp_y, rsp_err}, 0);
        chk("rst_cnt0", cnt0, 0);
        chk("rst_cnt1", cnt1, 0);
        tick();
        rstn = 1'b1;
        tick();

        // Basic fle: 1.0 <= 2.0
        do_op("fle", 0, 2'b10, 32'h3F800000, 32'h40000000, 1, 0);
        chk("fle_cnt0", cnt0, 1);

        // Zero/denormal and negative ordering on requester 1
        do_op("feq_zero", 1, 2'b00, 32'h80000000, 32'h00000001, 1, 0);
        do_op("flt_neg_zero", 1, 2'b01, 32'hBF800000, 32'h00000000, 1, 0);
        do_op("flt_neg_neg", 1, 2'b01, 32'hC0000000, 32'hBF800000, 1, 0);
        chk("zero_cnt1", cnt1, 3);

        // Reserved op: false with error, still counted
        do_op("rsv", 0, 2'b11, 32'h3F800000, 32'h3F800000, 0, 1);
        chk("rsv_cnt0", cnt0, 2);

        // Backpressure: feq 1.0 == 1.0 held while requester 1 waits
        rsp0_ready = 0;
        set_req(0, 1'b1, 2'b00, 32'h3F800000, 32'h3F800000);
        #1;
        chk("bp_rdy0", req0_ready, 1);
        tick();
        set_req(0, 1'b0, 2'b00, 32'h0, 32'h0);
        set_req(1, 1'b1, 2'b10, 32'h40000000, 32'h3F800000);   // fle 2.0 <= 1.0 -> 0
        #1;
        chk("bp_cmp_rdy1", req1_ready, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_hold_vld", rsp0_valid, 1);
            chk("bp_hold_y", rsp_y, 1);
            chk("bp_hold_rdy1", req1_ready, 0);
            tick();
        end
        rsp0_ready = 1;
        #1;
        chk("bp_rel_rdy1", req1_ready, 1);
        chk("bp_rel_vld", rsp0_valid, 1);
        tick();
        set_req(1, 1'b0, 2'b00, 32'h0, 32'h0);
        chk("bp_cnt0", cnt0, 3);
        tick();
        chk("bp_r1_vld", {rsp1_valid, rsp0_valid}, 2'b10);
        chk("bp_r1_y", rsp_y, 0);
        tick();
        chk("bp_cnt1", cnt1, 4);

        // Reset during CMP discards the op
        set_req(0, 1'b1, 2'b01, 32'h3F800000, 32'h40000000);
        tick();
        set_req(0, 1'b0, 2'b00, 32'h0, 32'h0);
        rstn = 1'b0;
        #1;
        chk("mrst_cnt0", cnt0, 0);
        chk("mrst_cnt1", cnt1, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("mrst_vld", {rsp0_valid, rsp1_valid}, 0);
        end
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mrst_post_vld", {rsp0_valid, rsp1_valid}, 0);
        end

        // Round-robin: req0 feq 1.0==2.0 -> 0, req1 flt 1.0<2.0 -> 1
        set_req(0, 1'b1, 2'b00, 32'h3F800000, 32'h40000000);
        set_req(1, 1'b1, 2'b01, 32'h3F800000, 32'h40000000);
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rr_rdy", {req1_ready, req0_ready}, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k > 0) begin
                chk("rr_vld", {rsp1_valid, rsp0_valid}, (k % 2 == 1) ? 2'b01 : 2'b10);
                chk("rr_y", rsp_y, (k % 2 == 1) ? 0 : 1);
            end
            tick();
            if (k == 6) req0_valid = 1'b0;
            if (k == 7) req1_valid = 1'b0;
            #1;
            chk("rr_cmp_rdy", {req1_ready, req0_ready}, 0);
            tick();
        end
        #1;
        chk("rr_last_vld", {rsp1_valid, rsp0_valid}, 2'b10);
        chk("rr_last_y", rsp_y, 1);
        tick();
        chk("rr_cnt0", cnt0, 4);
        chk("rr_cnt1", cnt1, 4);
        chk("rr_idle_vld", {rsp0_valid, rsp1_valid}, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fcmp_arbiter.md
Name: fcmp_arbiter

Overview:
- Shares one registered single-precision compare unit between two requesters: requester 0 is the integer-pipeline FPU issue, requester 1 is the load/store or microcode sequencer.
- Supports feq, flt and fle, with round-robin arbitration and valid/ready handshakes on both request and response sides.
- Uses the FPU-wide ordering rules: exponent==0 is zero, and denormals are flushed.
- Keeps per-requester completion counters for performance counters.

Parameters:
CNT_W, 16, width of each per-requester completed-operation counter (saturating)

Ports:
clk  input  1  single clock, rising edge
rstn  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle when valid&ready
req0_op  input  2  00 feq, 01 flt, 10 fle, 11 reserved
req0_x1  input  32  operand x1 (IEEE-754 single)
req0_x2  input  32  operand x2
req1_valid / req1_ready / req1_op / req1_x1 / req1_x2  as above, for requester 1
rsp0_valid  output  1  result for requester 0 available
rsp0_ready  input  1  requester 0 consumes result
rsp1_valid / rsp1_ready  as above, for requester 1
rsp_y  output  1  comparison result, 1 = true (shared by both response ports)
rsp_err  output  1  1 when the op code was 11
cnt0  output  CNT_W  completed responses for requester 0
cnt1  output  CNT_W  completed responses for requester 1

Behaviour:
- Operand class for each operand:
  - ZERO if bits[30:23]==0, whatever the sign or mantissa.
  - POS if sign=0 and not ZERO.
  - NEG otherwise.
  - Class order is NEG < ZERO < POS.
- Class rules:
  - Different classes: the class order decides.
  - Both POS: compare bits[30:0] unsigned.
  - Both NEG: compare reversed (x2[30:0] vs x1[30:0]).
  - Both ZERO: equal.
- Op results:
  - fle = lt|eq; flt = lt; feq = eq.
  - eq means same class and bits[30:0] equal; both ZERO is always eq.
  - No NaN special-casing: NaNs order by their bits under the rules above.
- FSM states: IDLE, CMP, RESP.
  - IDLE: req_ready is high for the granted requester only. On the valid&ready handshake, latch op, x1, x2 and owner, then go to CMP.
  - CMP: compute the result into the rsp_y / rsp_err registers, then go to RESP. A request accepted in cycle N gives rsp valid in cycle N+2.
  - RESP: rsp{owner}_valid=1; the other rsp_valid is 0.
    - On rsp{owner}_ready: increment cnt{owner}, saturating at all-ones.
    - If a request is pending in that same cycle, accept it (req_ready asserted combinationally) and go to CMP.
    - Otherwise go to IDLE.
    - Without rsp_ready, hold all response outputs stable.
- Arbitration:
  - last_grant register, reset value 1, so requester 0 wins first.
  - When both are valid, grant !last_grant. When only one is valid, grant it.
  - last_grant updates only on an accepted handshake.
  - req_ready is never high for both requesters in the same cycle, and is never high in CMP.
- Reserved op 11: rsp_y=0, rsp_err=1, and the response still completes and counts.
- Requester withdrawing valid before it is granted is legal and causes no side effect.
- Reset values (asserted asynchronously at any time):
  - State IDLE.
  - All rsp_valid 0, rsp_y 0, rsp_err 0.
  - cnt0 = cnt1 = 0, last_grant 1.
  - Latched operands 0.
  - Any in-flight operation is discarded and produces no response.
  - Release of reset is synchronous to clk.

Decomposition:
- Package fcmp_pkg:
  - op enum (OP_FEQ, OP_FLT, OP_FLE, OP_RSV).
  - FSM state enum (S_IDLE, S_CMP, S_RESP).
  - class enum (CL_NEG=0, CL_ZERO=1, CL_POS=2).
  - Exponent field constants EXP_MSB=30, EXP_LSB=23.
- Sub-module fcmp_core: purely combinational. Inputs op, x1, x2; outputs y, err. Instantiated once, fed from the latched operands.
- Arbiter, FSM and counters live in fcmp_arbiter.

Test Plan:
- Basic fle compare:
  - Stimulus: req0 fle x1=0x3F800000, x2=0x40000000, rsp0_ready=1.
  - Response: req0_ready high in cycle 0, rsp0_valid in cycle 2, rsp_y=1, cnt0=1.
- Zero and denormal ordering:
  - req1 feq x1=0x80000000, x2=0x00000001 -> rsp_y=1.
  - flt x1=0xBF800000, x2=0x00000000 -> rsp_y=1.
  - flt x1=0xC0000000, x2=0xBF800000 -> rsp_y=1.
- Round-robin contention:
  - Stimulus: both requesters valid continuously with 4 ops each.
  - Response: grant order 0,1,0,1,...; each accept occurs in the same cycle as the previous response handshake; cnt0=cnt1=4.
- Response backpressure:
  - Stimulus: rsp0_ready low for 5 cycles, with req1 valid.
  - Response: rsp0_valid and rsp_y stable throughout, req1_ready stays 0, req1 is granted on the release cycle.
- Reserved op:
  - Stimulus: req0 op=11.
  - Response: rsp_y=0, rsp_err=1, cnt0 increments.
- Reset mid-operation:
  - Stimulus: drop rstn during CMP.
  - Response: rsp0_valid never asserts, counters read 0, the next request after release is granted to requester 0.
